// File: rtl/mips_pkg.sv
// Shared MIPS front-end encodings: branch/jump type codes, default vectors
// and the PC unit's two-state type.
package mips_pkg;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  localparam logic [1:0] J_NONE = 2'd0;
  localparam logic [1:0] J_IDX  = 2'd1;
  localparam logic [1:0] J_REG  = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef logic pc_state_t;
  localparam pc_state_t ST_IDLE = 1'b0;
  localparam pc_state_t ST_PEND = 1'b1;

endpackage

// File: rtl/branch_cmp.sv
// Signed branch-condition evaluator for the six MIPS conditional branches;
// reserved and none encodings never report taken.
module branch_cmp
  import mips_pkg::*;
(
  input  logic [2:0]  br_type,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        taken
);

  logic rs_zero;
  logic rs_neg;

  always_comb begin
    rs_zero = (rs_val == 32'd0);
    rs_neg  = rs_val[31];
    taken   = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (rs_val == rt_val);
      BR_BNE:  taken = (rs_val != rt_val);
      BR_BLEZ: taken = rs_neg | rs_zero;
      BR_BGTZ: taken = !rs_neg && !rs_zero;
      BR_BLTZ: taken = rs_neg;
      BR_BGEZ: taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection: branches, jumps, exception entry/eret,
// and a one-deep redirect buffer while fetch stalls. Optional: PC_ALIGN_CHK_EN.
module pc_next_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_ready,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [2:0]        br_type,
  input  logic [1:0]        j_type,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic [15:0]       imm16,
  input  logic [25:0]       index,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] link_addr,
`ifdef PC_ALIGN_CHK_EN
  output logic              misalign,
`endif
  output logic              redirect
);

  localparam int unsigned AW = ADDR_W;

  pc_state_t         state, state_nxt;
  logic [AW-1:0]     pend_tgt, pend_nxt;
  logic [AW-1:0]     pc_nxt;
  logic [AW-1:0]     br_tgt, j_tgt, tgt;
  logic              br_taken;

  branch_cmp u_branch_cmp (
    .br_type (br_type),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .taken   (br_taken)
  );

  // Redirect qualification and target; a valid jump type overrides any branch.
  always_comb begin
    br_tgt    = pc_d + AW'(4) + AW'({{14{imm16[15]}}, imm16, 2'b00});
    j_tgt     = {pc_d[AW-1:28], index, 2'b00};
    link_addr = pc_d + AW'(8);
    redirect  = 1'b0;
    tgt       = br_tgt;
    if (d_valid) begin
      if (j_type == J_IDX) begin
        redirect = 1'b1;
        tgt      = j_tgt;
      end else if (j_type == J_REG) begin
        redirect = 1'b1;
        tgt      = rs_val[AW-1:0];
      end else begin
        redirect = br_taken;
      end
    end
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_tgt;
    if (exc_req) begin
      pc_nxt    = AW'(EXC_VEC);
      state_nxt = ST_IDLE;
      pend_nxt  = '0;
    end else if (eret) begin
      pc_nxt    = epc;
      state_nxt = ST_IDLE;
      pend_nxt  = '0;
    end else begin
      case (state)
        ST_PEND: begin
          if (if_ready) begin
            pc_nxt    = pend_tgt;
            state_nxt = ST_IDLE;
          end else if (redirect) begin
            pend_nxt = tgt;
          end
        end
        default: begin
          if (if_ready) begin
            pc_nxt = redirect ? tgt : pc + AW'(4);
          end else if (redirect) begin
            pend_nxt  = tgt;
            state_nxt = ST_PEND;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= AW'(RESET_PC);
      pc4      <= AW'(RESET_PC) + AW'(4);
      pend_tgt <= '0;
`ifdef PC_ALIGN_CHK_EN
      misalign <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc4      <= pc_nxt + AW'(4);
      pend_tgt <= pend_nxt;
`ifdef PC_ALIGN_CHK_EN
      misalign <= |pc_nxt[1:0];
`endif
    end
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter and next-PC generator for the MIPS pipeline, sitting between the hazard unit, decode-stage branch resolution and instruction fetch. It owns the PC register and resolves six conditional branch types, j/jal and jr/jalr redirects, exception entry and eret return with fixed priority. It holds the PC while fetch is not ready and buffers a redirect that arrives during that wait. Address width, reset vector and exception vector are parameters.

## Interface
- ADDR_W, 32, PC width; legal range 29..32.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception entry address.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- if_ready  in  1  fetch accepted the current pc this cycle.
- d_valid  in  1  decode-stage instruction valid and not stalled by the hazard unit.
- pc_d  in  ADDR_W  PC of the instruction in decode.
- br_type  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
- j_type  in  2  0 none, 1 j/jal (index), 2 jr/jalr (rs_val), 3 reserved (treated as none).
- rs_val, rt_val  in  32  forwarded operands; all comparisons are signed.
- imm16  in  16  branch offset.
- index  in  26  jump index.
- exc_req  in  1  exception entry request.
- eret  in  1  exception return.
- epc  in  ADDR_W  eret return address.
- pc  out  ADDR_W  current fetch address.
- pc4  out  ADDR_W  pc + 4.
- link_addr  out  ADDR_W  pc_d + 8 (jal/jalr link value).
- redirect  out  1  a qualified branch or jump is taken this cycle.
- misalign  out  1  pc[1:0] != 0; present only with PC_ALIGN_CHK_EN.

## Operation
- Branch target: pc_d + 4 + (sign-extended imm16 << 2). Result is truncated to ADDR_W.
- j target: {pc_d[ADDR_W-1:28], index, 2'b00}.
- jr target: rs_val[ADDR_W-1:0].
- Taken conditions: beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0.
- Branch and jump inputs count only when d_valid=1. If br_type and j_type are both nonzero, j_type wins.
- Next-PC priority: exc_req (EXC_VEC) > eret (epc) > pending target > current taken redirect > pc+4.
- exc_req and eret do not depend on d_valid or if_ready. They load pc on the next edge and clear any pending target.
- State machine has two states:
  - IDLE: if if_ready=1, pc takes the next-PC value. If if_ready=0 and redirect=1, the target is latched into pend_tgt and the state moves to PEND; otherwise pc holds.
  - PEND: pc holds while if_ready=0. When if_ready=1, pc <= pend_tgt and the state returns to IDLE.
  - In PEND, a new qualified redirect overwrites pend_tgt (youngest wins).
- redirect is combinational from the current inputs. It is independent of the state.

## Timing
- Reset values: pc=RESET_PC, pc4=RESET_PC+4, state IDLE, pend_tgt=0, misalign=0. reset overrides exc_req and all other inputs.
- Redirect to fetch latency is one edge: target visible on pc in the cycle after the redirect.
- Exception and eret latency is one edge, regardless of if_ready.
- link_addr is combinational from pc_d.
- Arithmetic wraps modulo 2^ADDR_W, with no overflow detection.

## Configuration
- PC_ALIGN_CHK_EN defined: the misalign port exists and is registered with pc, so it asserts in the same cycle a misaligned pc appears. The misaligned value is still loaded; the exception unit reacts to misalign.
- PC_ALIGN_CHK_EN undefined: the misalign port and its register are absent. jr targets load unchanged.

## Structure
- Shared package mips_pkg holds:
  - br_type encodings BR_NONE..BR_BGEZ;
  - j_type encodings J_NONE, J_IDX, J_REG;
  - the default RESET_PC and EXC_VEC constants;
  - the two-state type.
- One sub-module, branch_cmp: combinational, takes br_type, rs_val and rt_val, and produces taken. It is reusable by a later EX-stage resolver.

## Test plan
- Reset, then if_ready=1 for 3 cycles: pc sequence 0x3000, 0x3004, 0x3008, 0x300C.
- pc_d=0x3010, beq with rs=rt=5, imm16=0xFFFC, d_valid=1: redirect=1, next pc=0x3004. Repeat with rt=6: pc+4.
- bltz with rs=0x8000_0000 gives taken; bgtz with rs=0 gives not taken; bgez with rs=0 gives taken.
- if_ready=0, j with pc_d=0x3020, index=0x0000100: pc holds and state is PEND. After 2 cycles if_ready=1: pc=0x0000_0400.
- exc_req while in PEND with if_ready=0: next pc=0x4180, pending cleared. eret with epc=0x3024 on the following cycle: pc=0x3024.
- With PC_ALIGN_CHK_EN: jr with rs=0x3002 gives pc=0x3002 and misalign=1 in the same cycle. With reset asserted together with exc_req: pc=0x3000.
